// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush control bundle between pipeline stages and pipe_ctrl.
// master drives stall requests and exception redirects; slave returns stall/flush/new_pc/bus_err/stall_cycles.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_err;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_if,
    output stallreq_id,
    output stallreq_ex,
    output stallreq_mem,
    output excp_req,
    output excp_pc,
    input  stall,
    input  flush,
    input  new_pc,
    input  bus_err,
    input  stall_cycles
  );

  modport slave (
    input  stallreq_if,
    input  stallreq_id,
    input  stallreq_ex,
    input  stallreq_mem,
    input  excp_req,
    input  excp_pc,
    output stall,
    output flush,
    output new_pc,
    output bus_err,
    output stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall mask, RUN/FLUSH/RESUME redirect FSM, data-SRAM timeout.
// Ports: clk, rst (sync, active-high), bus (pipe_ctrl_if.slave); PIPE_CTRL_PERF_CNT_EN enables stall_cycles.
module pipe_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] FLUSH  = 2'b01;
  localparam logic [1:0] RESUME = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic [7:0]  wait_cnt;
  logic        bus_err_q;
  logic [5:0]  run_mask;
  logic [5:0]  stall_d;

  // Deepest requester wins: everything upstream of it holds too.
  always_comb begin
    run_mask = 6'b000000;
    if (bus.stallreq_mem)
      run_mask = 6'b011111;
    else if (bus.stallreq_ex)
      run_mask = 6'b001111;
    else if (bus.stallreq_id)
      run_mask = 6'b000111;
    else if (bus.stallreq_if)
      run_mask = 6'b000011;
  end

  // RESUME holds the PC one extra cycle so the redirect fetch lands.
  always_comb begin
    stall_d = 6'b000000;
    if (!rst) begin
      case (state)
        RUN:     stall_d = run_mask;
        RESUME:  stall_d = run_mask | 6'b000001;
        default: stall_d = 6'b000000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (bus.excp_req) begin
            state    <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= bus.excp_pc;
          end
        end
        FLUSH: begin
          state   <= RESUME;
          flush_q <= 1'b0;
        end
        RESUME: begin
          state <= RUN;
        end
        default: begin
          state   <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  // Timeout counts only RUN cycles; any gap or redirect restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 8'h0;
      bus_err_q <= 1'b0;
    end else if (state == RUN && bus.stallreq_mem) begin
      if (wait_cnt == WAIT_LAST) begin
        wait_cnt  <= 8'h0;
        bus_err_q <= 1'b1;
      end else begin
        wait_cnt  <= wait_cnt + 8'h1;
        bus_err_q <= 1'b0;
      end
    end else begin
      wait_cnt  <= 8'h0;
      bus_err_q <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 32'h0;
    else if (stall_d[0])
      stall_cnt <= stall_cnt + 32'h1;
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 32'h0;
`endif

  assign bus.stall   = stall_d;
  assign bus.flush   = flush_q;
  assign bus.new_pc  = new_pc_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl with MAX_WAIT=4.
// Inputs change on negedge; comb outputs read #1 later, registered ones at next negedge.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] req, input logic ex,
                       input logic [31:0] pc);
    {bus.stallreq_mem, bus.stallreq_ex,
     bus.stallreq_id, bus.stallreq_if} = req;
    bus.excp_req = ex;
    bus.excp_pc  = pc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(4'b1111, 1'b1, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (bus.stall !== 6'b000000)
      $display("FAIL reset_stall got %b want 000000", bus.stall);
    else pass_cnt++;
    total++;
    if (bus.flush !== 1'b0)
      $display("FAIL reset_flush got %b want 0", bus.flush);
    else pass_cnt++;
    total++;
    if (bus.new_pc !== 32'h0)
      $display("FAIL reset_new_pc got %h want 0", bus.new_pc);
    else pass_cnt++;
    total++;
    if (bus.bus_err !== 1'b0)
      $display("FAIL reset_bus_err got %b want 0", bus.bus_err);
    else pass_cnt++;
    total++;
    if (bus.stall_cycles !== 32'h0)
      $display("FAIL reset_stall_cycles got %0d want 0",
               bus.stall_cycles);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 1'b0, 32'h0);
  endtask

  task automatic test_run_mask;
    logic [3:0] req [6];
    logic [5:0] exp [6];
    req = '{4'b1010, 4'b0001, 4'b0101, 4'b0010, 4'b1000, 4'b0000};
    exp = '{6'b011111, 6'b000011, 6'b001111,
            6'b000111, 6'b011111, 6'b000000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(req[i], 1'b0, 32'h0);
      #1;
      total++;
      if (bus.stall !== exp[i])
        $display("FAIL run_mask[%0d] got %b want %b",
                 i, bus.stall, exp[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
  endtask

  task automatic test_exception;
    @(negedge clk);
    drive(4'b0000, 1'b1, 32'hbfc0_0380);
    #1;
    total++;
    if (bus.flush !== 1'b0)
      $display("FAIL exc_pre_flush got %b want 0", bus.flush);
    else pass_cnt++;
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    total++;
    if ({bus.flush, bus.stall} !== 7'b1_000000)
      $display("FAIL exc_flush got flush=%b stall=%b want 1/000000",
               bus.flush, bus.stall);
    else pass_cnt++;
    total++;
    if (bus.new_pc !== 32'hbfc0_0380)
      $display("FAIL exc_new_pc got %h want bfc00380", bus.new_pc);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total++;
    if ({bus.flush, bus.stall} !== 7'b0_000001)
      $display("FAIL exc_resume got flush=%b stall=%b want 0/000001",
               bus.flush, bus.stall);
    else pass_cnt++;
    drive(4'b0100, 1'b0, 32'h0);
    #1;
    total++;
    if (bus.stall !== 6'b001111)
      $display("FAIL exc_resume_ex got %b want 001111", bus.stall);
    else pass_cnt++;
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    total++;
    if ({bus.flush, bus.stall} !== 7'b0_000000)
      $display("FAIL exc_run got flush=%b stall=%b want 0/000000",
               bus.flush, bus.stall);
    else pass_cnt++;
    total++;
    if (bus.new_pc !== 32'hbfc0_0380)
      $display("FAIL exc_hold_pc got %h want bfc00380", bus.new_pc);
    else pass_cnt++;
  endtask

  task automatic test_excp_hold;
    logic [31:0] pcs [3];
    logic [1:0]  expf [4];
    pcs  = '{32'h8000_0100, 32'h8000_0200, 32'h8000_0300};
    expf = '{2'b10, 2'b00, 2'b00, 2'b00};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1, pcs[i]);
      @(negedge clk);
      total++;
      if (bus.flush !== expf[i][1] || bus.new_pc !== 32'h8000_0100)
        $display("FAIL excp_hold[%0d] got flush=%b pc=%h want %b/80000100",
                 i, bus.flush, bus.new_pc, expf[i][1]);
      else pass_cnt++;
    end
    drive(4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.flush !== 1'b0 || bus.new_pc !== 32'h8000_0100)
      $display("FAIL excp_hold_end got flush=%b pc=%h want 0/80000100",
               bus.flush, bus.new_pc);
    else pass_cnt++;
  endtask

  task automatic test_bus_err;
    logic exp;
    for (int i = 1; i <= 10; i++) begin
      drive(4'b1000, 1'b0, 32'h0);
      #1;
      total++;
      if (bus.stall !== 6'b011111)
        $display("FAIL bus_err_stall[%0d] got %b want 011111",
                 i, bus.stall);
      else pass_cnt++;
      @(negedge clk);
      exp = (i == 4 || i == 8);
      total++;
      if (bus.bus_err !== exp)
        $display("FAIL bus_err[%0d] got %b want %b", i, bus.bus_err, exp);
      else pass_cnt++;
    end
    drive(4'b0000, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_excp_and_bus_err;
    for (int i = 1; i <= 4; i++) begin
      drive(4'b1000, i == 4, 32'h0000_4444);
      @(negedge clk);
    end
    drive(4'b0000, 1'b0, 32'h0);
    total++;
    if ({bus.bus_err, bus.flush} !== 2'b11 || bus.new_pc !== 32'h4444)
      $display("FAIL excp_bus_err got err=%b flush=%b pc=%h want 1/1/4444",
               bus.bus_err, bus.flush, bus.new_pc);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rst_flush;
    drive(4'b0000, 1'b1, 32'hdead_beef);
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    total++;
    if (bus.flush !== 1'b1)
      $display("FAIL rst_flush_pre got %b want 1", bus.flush);
    else pass_cnt++;
    rst = 1'b1;
    drive(4'b1000, 1'b0, 32'h0);
    #1;
    total++;
    if (bus.stall !== 6'b000000)
      $display("FAIL rst_hold_stall got %b want 000000", bus.stall);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    total++;
    if ({bus.flush, bus.stall} !== 7'b0 || bus.new_pc !== 32'h0)
      $display("FAIL rst_flush got flush=%b stall=%b pc=%h want 0/000000/0",
               bus.flush, bus.stall, bus.new_pc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_perf;
    logic [31:0] exp;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp = 32'd6;
`else
    exp = 32'd0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 1'b0, 32'h0);
      @(negedge clk);
    end
    drive(4'b0000, 1'b1, 32'h0000_0040);
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.stall_cycles !== exp)
      $display("FAIL perf_cnt got %0d want %0d", bus.stall_cycles, exp);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset();
    test_run_mask();
    test_exception();
    test_excp_hold();
    test_bus_err();
    test_excp_and_bus_err();
    test_rst_flush();
    test_perf();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, default 15, number of consecutive data-SRAM wait cycles that triggers bus_err (legal range 1..255).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stallreq_if  in  1  instruction SRAM not ready.
REQ-005 stallreq_id  in  1  load-use hazard detected in ID.
REQ-006 stallreq_ex  in  1  multi-cycle EX unit (divider) busy.
REQ-007 stallreq_mem  in  1  data SRAM not ready.
REQ-008 excp_req  in  1  exception/redirect request.
REQ-009 excp_pc  in  32  redirect target, valid with excp_req.
REQ-010 stall  out  `StallBus (6)  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
REQ-011 flush  out  1  clears all pipeline registers, registered.
REQ-012 new_pc  out  32  PC to load while flush=1, registered.
REQ-013 bus_err  out  1  one-cycle pulse on data-SRAM timeout.
REQ-014 stall_cycles  out  32  count of cycles with stall[0]=1.

Function
REQ-015 FSM states RUN, FLUSH, RESUME shall be implemented; transitions occur only on posedge clk.
REQ-016 In RUN, stall shall be the mask of the deepest active requester: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-017 Stall outputs in RUN shall be combinational from the request inputs (zero-cycle latency).
REQ-018 RUN with excp_req=1 shall capture excp_pc into new_pc and enter FLUSH on the next edge, regardless of stall requests.
REQ-019 In FLUSH, flush shall be 1 and stall shall be 6'b000000 for exactly one cycle; the next state is RESUME.
REQ-020 In RESUME, stall shall be 6'b000001 OR'd with the RUN mask of REQ-016 for one cycle; the next state is RUN.
REQ-021 excp_req asserted in FLUSH or RESUME shall be ignored; new_pc shall not change.
REQ-022 flush shall be 0 in RUN and RESUME; new_pc shall hold its last captured value.
REQ-023 A wait counter (8 bits) shall increment each RUN cycle with stallreq_mem=1 and clear to 0 on any cycle with stallreq_mem=0 or state not RUN.
REQ-024 When the wait counter equals MAX_WAIT-1 and stallreq_mem=1, bus_err shall pulse 1 on the next cycle and the counter shall clear to 0; the stall mask is unaffected.
REQ-025 Simultaneous excp_req and bus_err condition in RUN: both shall take effect (bus_err pulse and FLUSH entry).

Reset
REQ-026 On rst=1: state RUN, flush 0, new_pc 32'h0, bus_err 0, wait counter 0, stall_cycles 0.
REQ-027 rst mid-FLUSH or mid-RESUME shall abort to RUN with the REQ-026 values on the next edge.
REQ-028 While rst=1, stall shall be 6'b000000 regardless of requests.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_CNT_EN defined: stall_cycles shall increment by 1 (wrapping 32'hffffffff to 0) on every non-reset cycle with stall[0]=1.
REQ-030 Macro PIPE_CTRL_PERF_CNT_EN undefined: no counter register shall exist and stall_cycles shall be tied to 32'h0.

Verification
REQ-031 stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111 that cycle; only stallreq_if=1 -> 6'b000011.
REQ-032 excp_req=1, excp_pc=32'hbfc00380 in RUN -> next cycle flush=1, new_pc=32'hbfc00380, stall=0; following cycle stall=6'b000001, flush=0; then RUN.
REQ-033 excp_req held high for 3 cycles with excp_pc changing -> single FLUSH cycle, new_pc equals the first-cycle value.
REQ-034 MAX_WAIT=4, stallreq_mem held 1 for 10 cycles -> bus_err pulses after cycle 4 and after cycle 8, stall=6'b011111 throughout.
REQ-035 rst asserted during FLUSH -> next cycle flush=0, new_pc=0, state RUN.
REQ-036 With PIPE_CTRL_PERF_CNT_EN, 5 cycles of stallreq_ex=1 plus 1 RESUME cycle -> stall_cycles=6; without the macro -> stall_cycles=0.
